multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter WAIT_LIMIT, 15, consecutive not-ready memory cycles tolerated before fault; 0 disables the watchdog.
REQ-002 Clk  in  1  single clock; all state updates on rising edge.
REQ-003 ResetN  in  1  asynchronous, active-low reset.
REQ-004 Opcode  in  6  instruction opcode from IR; stable from DECODE until the next FETCH.
REQ-005 Zero  in  1  ALU zero flag, sampled in BRANCH.
REQ-006 MemReady  in  1  memory completes the current access this cycle.
REQ-007 Outputs, 1 bit each: PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, Fault.
REQ-008 Outputs, 2 bits each: ALUSrcB, ALUOp, PCSource.
REQ-009 State  out  4  current state encoding, for debug.

Function
REQ-010 FSM states and encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, FAULT=10.
REQ-011 Outputs SHALL be combinational from State, gated only by MemReady and Zero where stated; any output not listed for a state SHALL be 0.
REQ-012 FETCH SHALL drive: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=MemReady, PCWrite=MemReady; FETCH SHALL go to DECODE on MemReady, otherwise hold.
REQ-013 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=00 and branch on Opcode: 000000 to EXEC; 100011 or 101011 to MEMADR; 000100 to BRANCH; any other opcode to FAULT.
REQ-014 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00, then go to MEMRD for 100011 and to MEMWR for 101011.
REQ-015 MEMRD SHALL drive MemRead=1, IorD=1 and go to MEMWB on MemReady, otherwise hold.
REQ-016 MEMWB SHALL drive RegWrite=1, MemtoReg=1, RegDst=0, then go to FETCH.
REQ-017 MEMWR SHALL drive MemWrite=1, IorD=1 and go to FETCH on MemReady, otherwise hold.
REQ-018 EXEC SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=10, then go to ALUWB.
REQ-019 ALUWB SHALL drive RegWrite=1, RegDst=1, MemtoReg=0, then go to FETCH.
REQ-020 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCWrite=Zero, then go to FETCH.
REQ-021 FAULT SHALL drive Fault=1 with all other outputs 0, and SHALL be left only by reset.
REQ-022 With zero-wait memory, instruction latency in cycles SHALL be: R-type 4, lw 5, sw 4, beq 3.
REQ-023 The wait counter SHALL clear on entry to FETCH, MEMRD or MEMWR, and on any cycle with MemReady=1.
REQ-024 The wait counter SHALL increment on each cycle spent in a wait state with MemReady=0.
REQ-025 If WAIT_LIMIT>0 and MemReady has been 0 for WAIT_LIMIT consecutive cycles in one wait state, the next edge SHALL go to FAULT.
REQ-026 When MemReady=1 coincides with the limit cycle, normal advance SHALL take precedence over FAULT.
REQ-027 The wait counter width SHALL be clog2(WAIT_LIMIT+1) and SHALL never wrap.

Reset
REQ-028 While ResetN=0, State SHALL be FETCH, the wait counter 0, and all outputs including Fault SHALL be forced to 0.
REQ-029 On ResetN release, fetch outputs SHALL appear; reset asserted mid-instruction SHALL abort the instruction immediately with no further write strobes.

Configuration
REQ-030 With MCCTRL_JUMP_EN defined, DECODE SHALL send Opcode 000010 to JUMP, which drives PCSource=10, PCWrite=1, then goes to FETCH (3-cycle j).
REQ-031 Without MCCTRL_JUMP_EN, Opcode 000010 SHALL be illegal and go to FAULT, and the JUMP encoding SHALL be unreachable.

Structure
REQ-032 A shared package SHALL hold the state encodings, opcode constants (RTYPE, LW, SW, BEQ, J), ALUOp codes (ADD=00, SUB=01, FUNCT=10) and ALUSrcB/PCSource select codes.
REQ-033 The watchdog SHALL be a sub-module mem_wait_timer (inputs: clear, count, MemReady; output: expired), parameterised by WAIT_LIMIT.

Verification
REQ-034 Zero-wait R-type (Opcode=000000) -> State 0,1,6,7,0; RegWrite=1 and RegDst=1 only in ALUWB.
REQ-035 lw with MemReady low for 3 cycles in MEMRD -> MEMRD held 4 cycles; total 8 cycles; no Fault.
REQ-036 beq with Zero=1, then beq with Zero=0 -> PCWrite=1 with PCSource=01 in BRANCH only for the first.
REQ-037 MemReady held 0 in FETCH, WAIT_LIMIT=15 -> FAULT after 15 cycles; Fault=1 until ResetN pulse; MemReady=1 exactly on cycle 15 -> DECODE instead.
REQ-038 Opcode 000010 -> JUMP with MCCTRL_JUMP_EN, FAULT without; Opcode 111111 -> FAULT in both builds.
REQ-039 ResetN asserted during MEMWR -> MemWrite drops to 0 asynchronously; after release State=0.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle controller: states, opcodes, datapath select codes.
// Latency: n/a (constants, types and one pure helper function only).
// Backpressure: n/a; memory stalls are handled by the FSM and its wait timer.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        FAULT  = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU operand B: register B, constant 4, sign-extended imm, imm shifted left by 2.
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // PC source: ALU result, ALUOut register, jump target.
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       fault;
    } ctrl_t;

    // States that stall on MemReady and are watched by the wait timer.
    function automatic logic is_wait_state(input state_t s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// Watchdog counting consecutive not-ready memory cycles; expired is combinational.
// Latency: expired asserts during the WAIT_LIMIT-th consecutive not-ready cycle.
// Backpressure: MemReady=1 clears the count and masks expiry, so a late completion wins.
module mem_wait_timer #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic Clk,
    input  logic ResetN,
    input  logic clear,
    input  logic count,
    input  logic MemReady,
    output logic expired
);

    generate
        if (WAIT_LIMIT > 0) begin : g_watchdog
            localparam int CW = $clog2(WAIT_LIMIT + 1);
            localparam logic [CW-1:0] LIMIT_MAX = CW'(WAIT_LIMIT);
            localparam logic [CW-1:0] LIMIT_M1  = CW'(WAIT_LIMIT - 1);

            logic [CW-1:0] cnt;

            // Count stalled cycles; saturate at the limit so the count never wraps.
            always_ff @(posedge Clk or negedge ResetN) begin
                if (!ResetN) begin
                    cnt <= '0;
                end else if (clear || MemReady) begin
                    cnt <= '0;
                end else if (count && (cnt != LIMIT_MAX)) begin
                    cnt <= cnt + 1'b1;
                end
            end

            // The current stalled cycle is the limit cycle when the prior count is LIMIT-1.
            always_comb begin
                expired = count && !MemReady && (cnt >= LIMIT_M1);
            end
        end else begin : g_no_watchdog
            assign expired = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM (R-type/lw/sw/beq, optional j via MCCTRL_JUMP_EN) with memory watchdog.
// Latency: R-type 4, lw 5, sw 4, beq 3, j 3 cycles with zero-wait memory; outputs are Moore plus MemReady/Zero gating.
// Backpressure: FETCH/MEMRD/MEMWR hold while MemReady=0; WAIT_LIMIT stalled cycles force FAULT until reset.
import multicycle_control_pkg::*;

module multicycle_control #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic       Clk,
    input  logic       ResetN,
    input  logic [5:0] Opcode,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       Fault,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] State
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;
    logic   wait_clear;
    logic   wait_count;
    logic   wait_expired;

    // Counter restarts on entry to a wait state and advances only while stalled in one.
    assign wait_clear = is_wait_state(state_d) && (state_d != state_q);
    assign wait_count = is_wait_state(state_q);

    mem_wait_timer #(
        .WAIT_LIMIT(WAIT_LIMIT)
    ) u_wait_timer (
        .Clk     (Clk),
        .ResetN  (ResetN),
        .clear   (wait_clear),
        .count   (wait_count),
        .MemReady(MemReady),
        .expired (wait_expired)
    );

    // State register; reset returns to FETCH and aborts any instruction in flight.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a completing access beats the watchdog; FAULT is sticky.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: begin
                if (MemReady)          state_d = DECODE;
                else if (wait_expired) state_d = FAULT;
            end
            DECODE: begin
                case (Opcode)
                    OP_RTYPE:     state_d = EXEC;
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_BEQ:       state_d = BRANCH;
`ifdef MCCTRL_JUMP_EN
                    OP_J:         state_d = JUMP;
`endif
                    default:      state_d = FAULT;
                endcase
            end
            MEMADR:  state_d = (Opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD: begin
                if (MemReady)          state_d = MEMWB;
                else if (wait_expired) state_d = FAULT;
            end
            MEMWB:   state_d = FETCH;
            MEMWR: begin
                if (MemReady)          state_d = FETCH;
                else if (wait_expired) state_d = FAULT;
            end
            EXEC:    state_d = ALUWB;
            ALUWB:   state_d = FETCH;
            BRANCH:  state_d = FETCH;
`ifdef MCCTRL_JUMP_EN
            JUMP:    state_d = FETCH;
`endif
            FAULT:   state_d = FAULT;
            default: state_d = FAULT;
        endcase
    end

    // Output decode; reset low forces every strobe off asynchronously.
    always_comb begin
        ctrl = '0;
        case (state_q)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = MemReady;
                ctrl.pc_write  = MemReady;
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.pc_source = PCSRC_ALUOUT;
                ctrl.pc_write  = Zero;
            end
`ifdef MCCTRL_JUMP_EN
            JUMP: begin
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.pc_write  = 1'b1;
            end
`endif
            FAULT:   ctrl.fault = 1'b1;
            default: ctrl = '0;
        endcase
        if (!ResetN) begin
            ctrl = '0;
        end
    end

    assign PCWrite  = ctrl.pc_write;
    assign IorD     = ctrl.i_or_d;
    assign MemRead  = ctrl.mem_read;
    assign MemWrite = ctrl.mem_write;
    assign IRWrite  = ctrl.ir_write;
    assign MemtoReg = ctrl.mem_to_reg;
    assign RegDst   = ctrl.reg_dst;
    assign RegWrite = ctrl.reg_write;
    assign ALUSrcA  = ctrl.alu_src_a;
    assign ALUSrcB  = ctrl.alu_src_b;
    assign ALUOp    = ctrl.alu_op;
    assign PCSource = ctrl.pc_source;
    assign Fault    = ctrl.fault;
    assign State    = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: instruction flows, stalls, watchdog, reset abort.
// Latency: checks are taken 2-3 time units after each rising edge, clear of the edge.
// Backpressure: MemReady is driven low in directed windows to exercise holds and the watchdog.
module tb_multicycle_control;

    logic       Clk;
    logic       ResetN;
    logic [5:0] Opcode;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, Fault;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] State;

    int tests_run = 0;
    int tests_failed = 0;

    // Output vector: {PCWrite,IorD,MemRead,MemWrite}_{IRWrite,MemtoReg,RegDst,RegWrite}_ALUSrcA_ALUSrcB_ALUOp_PCSource_Fault
    logic [15:0] outs;
    assign outs = {PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
                   ALUSrcA, ALUSrcB, ALUOp, PCSource, Fault};

    localparam logic [15:0] O_NONE    = 16'b0000_0000_0_00_00_00_0;
    localparam logic [15:0] O_FETCH_W = 16'b0010_0000_0_01_00_00_0;
    localparam logic [15:0] O_FETCH_R = 16'b1010_1000_0_01_00_00_0;
    localparam logic [15:0] O_DECODE  = 16'b0000_0000_0_11_00_00_0;
    localparam logic [15:0] O_MEMADR  = 16'b0000_0000_1_10_00_00_0;
    localparam logic [15:0] O_MEMRD   = 16'b0110_0000_0_00_00_00_0;
    localparam logic [15:0] O_MEMWB   = 16'b0000_0101_0_00_00_00_0;
    localparam logic [15:0] O_MEMWR   = 16'b0101_0000_0_00_00_00_0;
    localparam logic [15:0] O_EXEC    = 16'b0000_0000_1_00_10_00_0;
    localparam logic [15:0] O_ALUWB   = 16'b0000_0011_0_00_00_00_0;
    localparam logic [15:0] O_BR_T    = 16'b1000_0000_1_00_01_01_0;
    localparam logic [15:0] O_BR_N    = 16'b0000_0000_1_00_01_01_0;
    localparam logic [15:0] O_JUMP    = 16'b1000_0000_0_00_00_10_0;
    localparam logic [15:0] O_FAULT   = 16'b0000_0000_0_00_00_00_1;

    multicycle_control #(.WAIT_LIMIT(15)) dut (
        .Clk     (Clk),
        .ResetN  (ResetN),
        .Opcode  (Opcode),
        .Zero    (Zero),
        .MemReady(MemReady),
        .PCWrite (PCWrite),
        .IorD    (IorD),
        .MemRead (MemRead),
        .MemWrite(MemWrite),
        .IRWrite (IRWrite),
        .MemtoReg(MemtoReg),
        .RegDst  (RegDst),
        .RegWrite(RegWrite),
        .ALUSrcA (ALUSrcA),
        .Fault   (Fault),
        .ALUSrcB (ALUSrcB),
        .ALUOp   (ALUOp),
        .PCSource(PCSource),
        .State   (State)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic chk_st(input string tag, input logic [3:0] exp_state, input logic [15:0] exp_outs);
        chk({tag, "_state"}, {12'd0, State}, {12'd0, exp_state});
        chk({tag, "_outs"}, outs, exp_outs);
    endtask

    initial begin
        ResetN   = 1'b0;
        Opcode   = 6'b000000;
        Zero     = 1'b0;
        MemReady = 1'b1;
        #12;
        chk_st("reset", 4'd0, O_NONE);

        // Release reset; fetch strobes appear, gated by MemReady.
        tick();
        ResetN = 1'b1;
        #1;
        chk_st("fetch_rdy", 4'd0, O_FETCH_R);
        MemReady = 1'b0;
        #1;
        chk("fetch_wait_outs", outs, O_FETCH_W);

        // R-type zero-wait: 0,1,6,7,0.
        Opcode   = 6'b000000;
        MemReady = 1'b1;
        tick(); chk_st("r_decode", 4'd1, O_DECODE);
        tick(); chk_st("r_exec",   4'd6, O_EXEC);
        tick(); chk_st("r_aluwb",  4'd7, O_ALUWB);
        tick(); chk_st("r_fetch",  4'd0, O_FETCH_R);

        // lw with MEMRD stalled 3 cycles: 8 cycles total, no fault.
        Opcode = 6'b100011;
        tick(); chk_st("lw_decode", 4'd1, O_DECODE);
        tick(); chk_st("lw_memadr", 4'd2, O_MEMADR);
        tick();
        MemReady = 1'b0;
        #1;
        chk_st("lw_memrd1", 4'd3, O_MEMRD);
        tick(); chk_st("lw_memrd2", 4'd3, O_MEMRD);
        tick(); chk_st("lw_memrd3", 4'd3, O_MEMRD);
        tick();
        MemReady = 1'b1;
        #1;
        chk_st("lw_memrd4", 4'd3, O_MEMRD);
        tick(); chk_st("lw_memwb", 4'd4, O_MEMWB);
        tick(); chk_st("lw_fetch", 4'd0, O_FETCH_R);

        // sw zero-wait: 0,1,2,5,0.
        Opcode = 6'b101011;
        tick(); chk_st("sw_decode", 4'd1, O_DECODE);
        tick(); chk_st("sw_memadr", 4'd2, O_MEMADR);
        tick(); chk_st("sw_memwr",  4'd5, O_MEMWR);
        tick(); chk_st("sw_fetch",  4'd0, O_FETCH_R);

        // sw aborted by reset while stalled in MEMWR.
        tick();
        tick();
        tick();
        MemReady = 1'b0;
        #1;
        chk_st("swa_memwr", 4'd5, O_MEMWR);
        tick();
        chk_st("swa_hold", 4'd5, O_MEMWR);
        ResetN = 1'b0;
        #1;
        chk_st("swa_abort", 4'd0, O_NONE);
        tick();
        ResetN = 1'b1;
        #1;
        chk_st("swa_release", 4'd0, O_FETCH_W);

        // beq taken then not taken.
        Opcode   = 6'b000100;
        MemReady = 1'b1;
        Zero     = 1'b1;
        tick(); chk_st("beq1_decode", 4'd1, O_DECODE);
        tick(); chk_st("beq1_branch", 4'd8, O_BR_T);
        tick(); chk_st("beq1_fetch",  4'd0, O_FETCH_R);
        Zero = 1'b0;
        tick(); chk_st("beq0_decode", 4'd1, O_DECODE);
        tick(); chk_st("beq0_branch", 4'd8, O_BR_N);
        tick(); chk_st("beq0_fetch",  4'd0, O_FETCH_R);

        // Watchdog: 15 stalled FETCH cycles go to FAULT, sticky until reset.
        MemReady = 1'b0;
        #1;
        for (int i = 0; i < 14; i++) tick();
        chk_st("wd_cycle15", 4'd0, O_FETCH_W);
        tick(); chk_st("wd_fault", 4'd10, O_FAULT);
        MemReady = 1'b1;
        Opcode   = 6'b000000;
        tick();
        tick(); chk_st("wd_sticky", 4'd10, O_FAULT);
        ResetN = 1'b0;
        #1;
        chk_st("wd_rst", 4'd0, O_NONE);
        tick();
        ResetN   = 1'b1;
        MemReady = 1'b0;
        #1;
        chk_st("wd_release", 4'd0, O_FETCH_W);

        // MemReady arriving exactly on the limit cycle advances instead of faulting.
        for (int i = 0; i < 14; i++) tick();
        chk("wd_edge_state", {12'd0, State}, 16'd0);
        MemReady = 1'b1;
        Opcode   = 6'b111111;
        tick(); chk_st("wd_edge_decode", 4'd1, O_DECODE);

        // Illegal opcode faults.
        tick(); chk_st("illegal_fault", 4'd10, O_FAULT);

        // Jump opcode: JUMP when enabled, FAULT otherwise.
        ResetN = 1'b0;
        tick();
        ResetN = 1'b1;
        Opcode = 6'b000010;
        tick(); chk_st("j_decode", 4'd1, O_DECODE);
        tick();
`ifdef MCCTRL_JUMP_EN
        chk_st("j_jump", 4'd9, O_JUMP);
        tick(); chk_st("j_fetch", 4'd0, O_FETCH_R);
`else
        chk_st("j_fault", 4'd10, O_FAULT);
        tick(); chk_st("j_sticky", 4'd10, O_FAULT);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
